// File: rtl/hs_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with a single registered output slot.
// Optional burst mode (define HS_ARB_BURST_EN) keeps a requester granted for up to BURST_LEN beats.
`timescale 1ns/1ps
module hs_rr_arbiter #(
    parameter int DW        = 8,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           valid_pre_i,
    input  logic [NREQ*DW-1:0]        data_pre_i,
    output logic [NREQ-1:0]           ready_pre_o,
    output logic                      valid_post_o,
    output logic [DW-1:0]             data_post_o,
    output logic [$clog2(NREQ)-1:0]   id_post_o,
    input  logic                      ready_post_i
);
    localparam int IW = $clog2(NREQ);

    logic            valid_reg;
    logic [DW-1:0]   data_reg;
    logic [IW-1:0]   id_reg;
    logic [IW-1:0]   ptr_reg;

    logic            load;
    logic            accept;
    logic [NREQ-1:0] above;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_id;
    logic [DW-1:0]   grant_data;

    // Requesters strictly above the last winner get first pick; otherwise wrap to the lowest index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_above
        assign above[gi] = (IW'(gi) > ptr_reg);
    end

    assign masked   = valid_pre_i & above;
    assign rr_grant = (|masked) ? (masked & (~masked + NREQ'(1)))
                                : (valid_pre_i & (~valid_pre_i + NREQ'(1)));

`ifdef HS_ARB_BURST_EN
    logic [3:0] burst_cnt_reg;
    logic       hold;

    assign hold  = (burst_cnt_reg != 4'd0) && (burst_cnt_reg < 4'(BURST_LEN)) && valid_pre_i[ptr_reg];
    assign grant = hold ? (NREQ'(1) << ptr_reg) : rr_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_reg <= 4'd0;
        end else if (accept) begin
            if (grant_id == ptr_reg && burst_cnt_reg < 4'(BURST_LEN))
                burst_cnt_reg <= burst_cnt_reg + 4'd1;
            else
                burst_cnt_reg <= 4'd1;
        end
    end
`else
    assign grant = rr_grant;
`endif

    // grant is one-hot or zero, so OR-ing the selected lanes is a clean mux.
    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                grant_id   = grant_id | IW'(k);
                grant_data = grant_data | data_pre_i[k*DW +: DW];
            end
        end
    end

    assign load        = !valid_reg || ready_post_i;
    assign ready_pre_o = load ? grant : '0;
    assign accept      = |ready_pre_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            id_reg    <= '0;
            ptr_reg   <= IW'(NREQ - 1);
        end else if (accept) begin
            valid_reg <= 1'b1;
            data_reg  <= grant_data;
            id_reg    <= grant_id;
            ptr_reg   <= grant_id;
        end else if (ready_post_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid_post_o = valid_reg;
    assign data_post_o  = data_reg;
    assign id_post_o    = id_reg;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter (default build): directed vector table, async-reset sequence,
// then random traffic against a round-robin reference model and an in-order scoreboard.
`timescale 1ns/1ps
module tb_hs_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    typedef struct {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic            r;
        logic [N-1:0]    rdy;
        logic            vp;
        logic [IW-1:0]   id;
        logic [DW-1:0]   dat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid_pre = '0;
    logic [N*DW-1:0] data_pre = '0;
    logic [N-1:0]    ready_pre;
    logic            valid_post;
    logic [DW-1:0]   data_post;
    logic [IW-1:0]   id_post;
    logic            ready_post = 1'b0;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic                 m_valid;
    int                   m_ptr;
    logic [IW+DW-1:0]     sb[$];
    int                   wait_cnt[N];
    int                   last_acc;

    hs_rr_arbiter #(.DW(DW), .NREQ(N), .BURST_LEN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_pre_i  (valid_pre),
        .data_pre_i   (data_pre),
        .ready_pre_o  (ready_pre),
        .valid_post_o (valid_post),
        .data_post_o  (data_post),
        .id_post_o    (id_post),
        .ready_post_i (ready_post)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (v[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r,
                                input logic [N-1:0] rdy, input logic vp, input logic [IW-1:0] id,
                                input logic [DW-1:0] dat);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.rdy = rdy; t.vp = vp; t.id = id; t.dat = dat;
        return t;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, then advance model past the posedge.
    task automatic cycle(input vec_t t, input bit chk);
        logic [N-1:0] er;
        logic [IW+DW-1:0] head;
        int dut_a;
        @(negedge clk);
        valid_pre  = t.v;
        data_pre   = t.d;
        ready_post = t.r;
        #1;
        er = (!m_valid || t.r) ? model_grant(t.v, m_ptr) : '0;
        check("ready_pre", 32'(ready_pre), 32'(er));
        check("onehot", 32'($countones(ready_pre) <= 1), 32'd1);
        check("valid_post", 32'(valid_post), 32'(m_valid));
        if (m_valid && sb.size() > 0) begin
            head = sb[0];
            check("sb_id", 32'(id_post), 32'(head[IW+DW-1:DW]));
            check("sb_data", 32'(data_post), 32'(head[DW-1:0]));
            if (t.r) void'(sb.pop_front());
        end
        if (chk) begin
            check("tab_ready_pre", 32'(ready_pre), 32'(t.rdy));
            check("tab_valid_post", 32'(valid_post), 32'(t.vp));
            check("tab_id_post", 32'(id_post), 32'(t.id));
            if (t.vp) check("tab_data_post", 32'(data_post), 32'(t.dat));
        end
        dut_a = -1;
        for (int k = 0; k < N; k++) if (ready_pre[k]) dut_a = k;
        for (int k = 0; k < N; k++) begin
            if (!t.v[k]) wait_cnt[k] = 0;
            else if (dut_a == k) begin
                check("max_wait", 32'(wait_cnt[k] <= N), 32'd1);
                wait_cnt[k] = 0;
            end else if (dut_a >= 0) wait_cnt[k]++;
        end
        last_acc = -1;
        for (int k = 0; k < N; k++) if (er[k]) last_acc = k;
        if (last_acc >= 0) begin
            sb.push_back({last_acc[IW-1:0], t.d[last_acc*DW +: DW]});
            m_ptr = last_acc;
        end
        m_valid = (last_acc >= 0) || (m_valid && !t.r);
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        valid_pre  = '0;
        ready_post = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_post), 32'd0);
        check("rst_data", 32'(data_post), 32'd0);
        check("rst_id", 32'(id_post), 32'd0);
        m_valid = 1'b0;
        m_ptr   = N - 1;
        sb.delete();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    localparam logic [N*DW-1:0] D1 = 32'h44332211;
    localparam logic [N*DW-1:0] D2 = 32'h00A50000;

    vec_t tab[20];
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;

    initial begin
        tab[0]  = mk(4'b1111, D1, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00);
        tab[1]  = mk(4'b1111, D1, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h11);
        tab[2]  = mk(4'b1111, D1, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h22);
        tab[3]  = mk(4'b1111, D1, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h33);
        tab[4]  = mk(4'b1111, D1, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h44);
        tab[5]  = mk(4'b1111, D1, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h11);
        tab[6]  = mk(4'b1010, D1, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h22);
        tab[7]  = mk(4'b1010, D1, 1'b1, 4'b0010, 1'b1, 2'd3, 8'h44);
        tab[8]  = mk(4'b1010, D1, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h22);
        tab[9]  = mk(4'b1010, D1, 1'b1, 4'b0010, 1'b1, 2'd3, 8'h44);
        tab[10] = mk(4'b0000, D1, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h22);
        tab[11] = mk(4'b0000, D1, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h00);
        tab[12] = mk(4'b0100, D2, 1'b0, 4'b0100, 1'b0, 2'd1, 8'h00);
        for (int i = 13; i <= 17; i++)
            tab[i] = mk(4'b0100, D2, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5);
        tab[18] = mk(4'b0000, D2, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hA5);
        tab[19] = mk(4'b0000, D2, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h00);

        do_reset();
        for (int i = 0; i < 20; i++) cycle(tab[i], 1'b1);

        // Reset while a beat is stalled in the output slot must clear it without a clock edge.
        cycle(mk(4'b0100, D2, 1'b0, '0, 1'b0, '0, '0), 1'b0);
        cycle(mk(4'b0000, D2, 1'b0, '0, 1'b0, '0, '0), 1'b0);
        check("stalled_valid", 32'(valid_post), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", 32'(valid_post), 32'd0);
        do_reset();
        cycle(mk(4'b1111, D1, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00), 1'b1);
        cycle(mk(4'b1111, D1, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h11), 1'b1);

        rv = '0;
        rd = '0;
        for (int c = 0; c < 10000; c++) begin
            cycle(mk(rv, rd, 1'($urandom_range(3) != 0), '0, 1'b0, '0, '0), 1'b0);
            for (int k = 0; k < N; k++) begin
                if (last_acc == k || !rv[k]) begin
                    rv[k] = 1'($urandom_range(1));
                    rd[k*DW +: DW] = DW'($urandom);
                end else if ($urandom_range(15) == 0) begin
                    rv[k] = 1'b0;
                end
            end
        end

        repeat (3) cycle(mk(4'b0000, rd, 1'b1, '0, 1'b0, '0, '0), 1'b0);
        #1 check("drained_valid", 32'(valid_post), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of every channel in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; legal values 2..8.
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive beats granted to one requester; legal values 1..15; used only when HS_ARB_BURST_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 valid_pre_i  input  NREQ  per-requester valid; bit k belongs to requester k.
REQ-007 data_pre_i  input  NREQ*DW  packed data; bits [k*DW +: DW] belong to requester k.
REQ-008 ready_pre_o  output  NREQ  per-requester ready; bit k belongs to requester k.
REQ-009 valid_post_o  output  1  registered output valid.
REQ-010 data_post_o  output  DW  registered output data.
REQ-011 id_post_o  output  clog2(NREQ)  index of the requester whose beat is held in the output register.
REQ-012 ready_post_i  input  1  downstream ready.

Function
REQ-013 Output stage is one register slot (valid_r, data_r, id_r), driving valid_post_o, data_post_o and id_post_o directly; no combinational path from data_pre_i to data_post_o.
REQ-014 load = !valid_r | ready_post_i: the slot accepts a new beat when empty or when draining in the same cycle.
REQ-015 grant is one-hot or zero; ready_pre_o = grant when load = 1, else all zero; at most one ready_pre_o bit is high in any cycle.
REQ-016 Round-robin grant: search valid_pre_i starting at index ptr+1 mod NREQ, ascending with wrap; grant the first set bit; grant = 0 when valid_pre_i = 0.
REQ-017 ready_pre_o may depend combinationally on valid_pre_i and ready_post_i; valid_pre_i must not depend on ready_pre_o.
REQ-018 Accept happens when valid_pre_i[k] & ready_pre_o[k]: next cycle valid_r = 1, data_r = data of k, id_r = k; latency input to output is 1 cycle.
REQ-019 When ready_post_i = 1, valid_r = 1 and no accept occurs, next valid_r = 0.
REQ-020 When valid_r = 1 and ready_post_i = 0: valid_r, data_r and id_r hold and ready_pre_o = 0.
REQ-021 ptr updates to k only on an accept from k; ptr holds in all other cycles.
REQ-022 Simultaneous drain and accept in one cycle gives one beat out and one beat in; sustained throughput is 1 beat/cycle.
REQ-023 A requester with valid held high is granted within NREQ accepts (BURST_LEN*(NREQ-1)+1 accepts with HS_ARB_BURST_EN); no starvation.
REQ-024 Dropping valid before acceptance is permitted; that requester is then simply not granted.

Reset
REQ-025 While rst_n = 0: valid_r = 0, data_r = 0, id_r = 0, ptr = NREQ-1 (requester 0 has highest priority first), burst counter = 0.
REQ-026 Reset asserted mid-transfer discards the held beat immediately; valid_post_o = 0 in the same cycle, without waiting for a clock edge.
REQ-027 First accept after reset release is possible on the first rising edge.

Configuration
REQ-028 Macro HS_ARB_BURST_EN undefined: rotation after every accept, per REQ-016; BURST_LEN is ignored and there is no burst counter.
REQ-029 HS_ARB_BURST_EN defined: after an accept from k, a burst counter increments; k stays granted while valid_pre_i[k] = 1 and the counter < BURST_LEN.
REQ-030 With HS_ARB_BURST_EN, the counter resets to 1 on an accept from a different requester.
REQ-031 With HS_ARB_BURST_EN, when the counter reaches BURST_LEN or valid_pre_i[k] = 0, grant moves to the REQ-016 search from k+1 in that same cycle.
REQ-032 With HS_ARB_BURST_EN and BURST_LEN = 1, behaviour is identical to the macro undefined.

Verification
REQ-033 After reset, valid_pre_i = 4'b1111, ready_post_i = 1 -> id_post_o sequence 0,1,2,3,0 on consecutive cycles; valid_post_o high continuously.
REQ-034 valid_pre_i = 4'b0100, data 8'hA5, ready_post_i = 0 -> beat accepted once, then ready_pre_o = 0 and data_post_o = 8'hA5 held for 5 cycles; release ready -> valid_post_o drops the next cycle.
REQ-035 valid_pre_i = 4'b1010, ready_post_i = 1 -> alternate ids 1,3,1,3; never two ready_pre_o bits high in the same cycle.
REQ-036 HS_ARB_BURST_EN, BURST_LEN = 4, valid_pre_i = 4'b0011 -> ids 0,0,0,0,1,1,1,1,0.
REQ-037 Assert rst_n low while valid_post_o = 1 and ready_post_i = 0 -> valid_post_o = 0 immediately; after release, the first grant goes to requester 0.
REQ-038 Random valid and ready traffic, 10k cycles -> scoreboard per id matches input order with no loss or duplication; max wait per requester <= NREQ accepts.
